// File: rtl/s_alloc_pkg.sv
// Shared widths and helpers for the circular slot allocator.
package s_alloc_pkg;

  // Widest occupancy bitmap the popcount helper accepts.
  localparam int unsigned POP_MAX_W = 1024;

  function automatic int unsigned idx_w(input int unsigned w);
    return $clog2(w);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Number of set bits; callers zero-extend narrower vectors.
  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/s.sv
// Combinational circular zero-finder: first clear bit of x_i scanning
// downward from pos_i-1, wrapping through W-1, ending at pos_i itself.
module s #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]         x_i,
  input  logic [$clog2(W)-1:0] pos_i,
  output logic [$clog2(W)-1:0] y_enc_o,
  output logic                 any_o
);

  localparam int unsigned IDX_W = $clog2(W);

  logic [IDX_W-1:0] cand;

  // Walk candidates farthest-first so the nearest free slot wins last.
  always_comb begin
    y_enc_o = pos_i;
    cand    = '0;
    for (int unsigned step = W; step >= 1; step--) begin
      cand = IDX_W'((32'(pos_i) + W - step) % W);
      if (!x_i[cand]) y_enc_o = cand;
    end
  end

  // Some slot is free whenever the bitmap is not all ones.
  always_comb begin
    any_o = ~&x_i;
  end

endmodule

// File: rtl/s_alloc.sv
// Sequential round-robin slot allocator over a W-entry occupancy bitmap.
// Offers one free slot per cycle on a registered valid/ready port and
// accepts up to N_FREE releases per cycle.
module s_alloc
  import s_alloc_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned N_FREE = 2
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          flush_i,
  output logic                          alloc_valid_o,
  output logic [$clog2(W)-1:0]          alloc_idx_o,
  input  logic                          alloc_ready_i,
  input  logic [N_FREE-1:0]             free_vld_i,
  input  logic [N_FREE*$clog2(W)-1:0]   free_idx_i,
  output logic [W-1:0]                  occ_o,
  output logic [$clog2(W+1)-1:0]        cnt_o,
  output logic                          err_o
);

  localparam int unsigned IDX_W = idx_w(W);
  localparam int unsigned CNT_W = cnt_w(W);

  logic [W-1:0]     occ_q, occ_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             offer_vld_q, offer_vld_d;
  logic [IDX_W-1:0] offer_idx_q, offer_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             fire;
  logic [IDX_W-1:0] fidx [N_FREE];
  logic [N_FREE-1:0] f_in_range;
  logic [W-1:0]     clr_mask;
  logic [W-1:0]     alloc_mask;
  logic             illegal;

  assign fire = offer_vld_q & alloc_ready_i;

  // Unpack release ports; only in-range strobes contribute to the clear mask.
  always_comb begin
    clr_mask   = '0;
    f_in_range = '0;
    for (int unsigned k = 0; k < N_FREE; k++) begin
      fidx[k]       = free_idx_i[k*IDX_W +: IDX_W];
      f_in_range[k] = (32'(fidx[k]) < W);
      if (free_vld_i[k] && f_in_range[k]) clr_mask[fidx[k]] = 1'b1;
    end
  end

  // Flag releases of free slots, duplicate releases, releases of the slot
  // being handed out this cycle, and out-of-range indices.
  always_comb begin
    illegal = 1'b0;
    for (int unsigned k = 0; k < N_FREE; k++) begin
      if (free_vld_i[k]) begin
        if (!f_in_range[k]) begin
          illegal = 1'b1;
        end else begin
          if (!occ_q[fidx[k]]) illegal = 1'b1;
          if (fire && (fidx[k] == offer_idx_q)) illegal = 1'b1;
        end
        for (int unsigned j = 0; j < k; j++) begin
          if (free_vld_i[j] && (fidx[j] == fidx[k])) illegal = 1'b1;
        end
      end
    end
  end

  // Next occupancy/pointer/error; allocation is applied after releases so a
  // slot both released and allocated in one cycle ends up occupied.
  always_comb begin
    alloc_mask = '0;
    if (fire) alloc_mask[offer_idx_q] = 1'b1;
    occ_d = (occ_q & ~clr_mask) | alloc_mask;
    ptr_d = fire ? offer_idx_q : ptr_q;
    err_d = err_q | illegal;
    if (flush_i) begin
      occ_d = '0;
      ptr_d = '0;
      err_d = 1'b0;
    end
    cnt_d = CNT_W'(popcount(POP_MAX_W'(occ_d)));
  end

  // Next offer is searched on next-state occupancy so no slot is offered twice.
  s #(.W(W)) u_search (
    .x_i     (occ_d),
    .pos_i   (ptr_d),
    .y_enc_o (offer_idx_d),
    .any_o   (offer_vld_d)
  );

  // State registers; the offered index holds while the pool is full.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      occ_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      offer_vld_q <= 1'b1;
      offer_idx_q <= IDX_W'(W - 1);
    end else begin
      occ_q       <= occ_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      offer_vld_q <= offer_vld_d;
      if (offer_vld_d) offer_idx_q <= offer_idx_d;
    end
  end

  assign alloc_valid_o = offer_vld_q;
  assign alloc_idx_o   = offer_idx_q;
  assign occ_o         = occ_q;
  assign cnt_o         = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_s_alloc.sv
// Bench for s_alloc (W=16, N_FREE=2): directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
`timescale 1ns/1ps
module tb_s_alloc;

  localparam int W = 16;

  logic        clk;
  logic        arst;
  logic        flush;
  logic        alloc_valid;
  logic [3:0]  alloc_idx;
  logic        alloc_ready;
  logic [1:0]  free_vld;
  logic [7:0]  free_idx;
  logic [15:0] occ;
  logic [4:0]  cnt;
  logic        err;

  int n_cmp = 0;
  int n_mis = 0;

  s_alloc #(.W(16), .N_FREE(2)) dut (
    .clk           (clk),
    .arst          (arst),
    .flush_i       (flush),
    .alloc_valid_o (alloc_valid),
    .alloc_idx_o   (alloc_idx),
    .alloc_ready_i (alloc_ready),
    .free_vld_i    (free_vld),
    .free_idx_i    (free_idx),
    .occ_o         (occ),
    .cnt_o         (cnt),
    .err_o         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_occ [W];
  int m_ptr;
  bit m_vld;
  int m_idx;
  bit m_err;

  task automatic model_reset();
    for (int i = 0; i < W; i++) m_occ[i] = 1'b0;
    m_ptr = 0;
    m_vld = 1'b1;
    m_idx = W - 1;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    bit fire;
    int fi [2];
    bit nocc [W];
    int found;
    fire = m_vld && alloc_ready;
    if (flush) begin
      model_reset();
      return;
    end
    fi[0] = int'(free_idx[3:0]);
    fi[1] = int'(free_idx[7:4]);
    nocc = m_occ;
    for (int k = 0; k < 2; k++) begin
      if (free_vld[k]) begin
        if (!m_occ[fi[k]]) m_err = 1'b1;
        if (fire && fi[k] == m_idx) m_err = 1'b1;
        nocc[fi[k]] = 1'b0;
      end
    end
    if (free_vld == 2'b11 && fi[0] == fi[1]) m_err = 1'b1;
    if (fire) begin
      nocc[m_idx] = 1'b1;
      m_ptr = m_idx;
    end
    m_occ = nocc;
    found = -1;
    for (int d = 1; d <= W; d++) begin
      int j;
      j = (m_ptr - d + W) % W;
      if (found < 0 && !m_occ[j]) found = j;
    end
    m_vld = (found >= 0);
    if (found >= 0) m_idx = found;
  endtask

  // Advance the model on each active edge, then compare after outputs settle.
  initial begin
    forever begin
      @(posedge clk);
      if (arst) model_reset();
      else model_step();
      #2;
      begin
        logic [15:0] mv;
        int mc;
        mc = 0;
        for (int i = 0; i < W; i++) begin
          mv[i] = m_occ[i];
          if (m_occ[i]) mc++;
        end
        chk("model_occ", 32'(occ), 32'(mv));
        chk("model_cnt", 32'(cnt), 32'(mc));
        chk("model_valid", 32'(alloc_valid), 32'(m_vld));
        chk("model_idx", 32'(alloc_idx), 32'(m_idx));
        chk("model_err", 32'(err), 32'(m_err));
      end
    end
  end

  // One cycle of stimulus: drive after a falling edge, land just after rising.
  task automatic step(input bit rdy, input logic [1:0] v, input int i0, input int i1, input bit fl);
    @(negedge clk);
    alloc_ready = rdy;
    free_vld    = v;
    free_idx    = {4'(i1), 4'(i0)};
    flush       = fl;
    @(posedge clk);
    #3;
    alloc_ready = 1'b0;
    free_vld    = '0;
    flush       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 0, 0, 1'b0);
  endtask

  initial begin
    arst = 1'b1; flush = 1'b0; alloc_ready = 1'b0; free_vld = '0; free_idx = '0;
    #1;
    chk("rst_occ", 32'(occ), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_valid", 32'(alloc_valid), 32'h1);
    chk("rst_idx", 32'(alloc_idx), 32'd15);
    chk("rst_err", 32'(err), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;

    // Fill from reset: 15 down to 0.
    for (int i = 0; i < 16; i++) begin
      chk("fill_idx", 32'(alloc_idx), 32'(15 - i));
      step(1'b1, 2'b00, 0, 0, 1'b0);
      chk("fill_cnt", 32'(cnt), 32'(i + 1));
    end
    chk("full_valid", 32'(alloc_valid), 32'h0);
    chk("full_err", 32'(err), 32'h0);
    chk("full_occ", 32'(occ), 32'hFFFF);

    // Ready while full is ignored; a release re-offers that slot.
    step(1'b1, 2'b00, 0, 0, 1'b0);
    chk("full_ready_cnt", 32'(cnt), 32'd16);
    step(1'b0, 2'b01, 5, 0, 1'b0);
    chk("rel5_valid", 32'(alloc_valid), 32'h1);
    chk("rel5_idx", 32'(alloc_idx), 32'd5);
    chk("rel5_cnt", 32'(cnt), 32'd15);
    step(1'b1, 2'b00, 0, 0, 1'b0);
    chk("refill_cnt", 32'(cnt), 32'd16);
    chk("refill_valid", 32'(alloc_valid), 32'h0);
    chk("refill_idx_hold", 32'(alloc_idx), 32'd5);
    // Pointer now 5: of slots 9 and 2, the search from 5 reaches 2 first.
    step(1'b0, 2'b11, 9, 2, 1'b0);
    chk("ptr5_idx", 32'(alloc_idx), 32'd2);

    // Alloc 15,14,13 then release 14,13 while allocating 12.
    step(1'b0, 2'b00, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 0, 0, 1'b0);
    chk("pre_mix_idx", 32'(alloc_idx), 32'd12);
    step(1'b1, 2'b11, 14, 13, 1'b0);
    chk("mix_idx", 32'(alloc_idx), 32'd11);
    chk("mix_occ", 32'(occ), 32'h9000);
    chk("mix_cnt", 32'(cnt), 32'd2);
    chk("mix_err", 32'(err), 32'h0);

    // Release of an already-free slot is sticky-illegal.
    step(1'b0, 2'b01, 3, 0, 1'b0);
    chk("free3_err", 32'(err), 32'h1);
    chk("free3_occ", 32'(occ), 32'h9000);
    idle(2);
    chk("free3_sticky", 32'(err), 32'h1);

    // Duplicate release of slot 7 on both ports.
    step(1'b0, 2'b00, 0, 0, 1'b1);
    chk("flush_err_clr", 32'(err), 32'h0);
    for (int i = 0; i < 9; i++) step(1'b1, 2'b00, 0, 0, 1'b0);
    chk("pre_dup_occ", 32'(occ), 32'hFF80);
    step(1'b0, 2'b11, 7, 7, 1'b0);
    chk("dup_err", 32'(err), 32'h1);
    chk("dup_occ", 32'(occ), 32'hFF00);
    chk("dup_idx", 32'(alloc_idx), 32'd6);

    // Release of the slot being allocated in the same cycle: slot stays taken.
    step(1'b0, 2'b00, 0, 0, 1'b1);
    step(1'b1, 2'b01, 15, 0, 1'b0);
    chk("selfrel_err", 32'(err), 32'h1);
    chk("selfrel_occ", 32'(occ), 32'h8000);

    // Flush on a full pool with ready high.
    step(1'b0, 2'b00, 0, 0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 2'b00, 0, 0, 1'b0);
    step(1'b1, 2'b00, 0, 0, 1'b1);
    chk("flfull_occ", 32'(occ), 32'h0);
    chk("flfull_cnt", 32'(cnt), 32'h0);
    chk("flfull_valid", 32'(alloc_valid), 32'h1);
    chk("flfull_idx", 32'(alloc_idx), 32'd15);
    // Flush coincident with a live handshake discards the allocation.
    step(1'b1, 2'b00, 0, 0, 1'b0);
    step(1'b1, 2'b00, 0, 0, 1'b1);
    chk("flhs_occ", 32'(occ), 32'h0);
    chk("flhs_idx", 32'(alloc_idx), 32'd15);

    // Asynchronous reset mid-stream.
    step(1'b1, 2'b00, 0, 0, 1'b0);
    step(1'b1, 2'b01, 2, 0, 1'b0);
    chk("pre_arst_err", 32'(err), 32'h1);
    #1;
    arst = 1'b1;
    #0.5;
    chk("arst_occ", 32'(occ), 32'h0);
    chk("arst_cnt", 32'(cnt), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    chk("arst_valid", 32'(alloc_valid), 32'h1);
    chk("arst_idx", 32'(alloc_idx), 32'd15);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;

    // Mixed traffic checked only by the model.
    for (int i = 0; i < 300; i++) begin
      logic [1:0] v;
      v = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      step(1'($urandom), v, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           ($urandom_range(0, 40) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
